// File: rtl/core_pkg.sv
// Types and constants shared by the pipeline sequencer and the pipeline registers.
package core_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StDmemWait  = 2'd1,
    StRedirPend = 2'd2
  } hazard_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use / branch / fetch-wait / dmem-wait handling for the 5-stage core,
// with PC redirect generation and stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic [31:0]      EX_target,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(DMEM_TIMEOUT);

  hazard_state_e    state_q, state_d;
  logic             resume_q, resume_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  logic             bus_err_q, bus_err_d;

  stage_ctrl_t if_id, id_ex;
  logic        pc_en, ex_mem_en, mem_wb_en;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        freeze, resume_redir, load_use, flush_inc, stall_inc;

  assign load_use = EX_MemRead && (EX_rd != REG_X0) &&
                    ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_uses_rs2 && (ID_rs2 == EX_rd)));

  assign wait_inc = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);

  // resume_q remembers whether a dmem freeze interrupted a pending redirect.
  always_comb begin
    freeze       = dmem_req && !dmem_ready;
    resume_redir = 1'b0;
    case (state_q)
      StDmemWait: begin
        freeze       = !dmem_ready;
        resume_redir = resume_q;
      end
      StRedirPend: resume_redir = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id       = '{en: 1'b1, flush: 1'b0};
    id_ex       = '{en: 1'b1, flush: 1'b0};
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;
    state_d     = StRun;
    resume_d    = 1'b0;
    redir_pc_d  = redir_pc_q;
    wait_d      = '0;
    bus_err_d   = bus_err_q;
    flush_inc   = 1'b0;

    if (freeze) begin
      pc_en     = 1'b0;
      if_id.en  = 1'b0;
      id_ex.en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = StDmemWait;
      resume_d  = resume_redir;
      wait_d    = wait_inc;
      if (wait_inc == WaitMax) begin
        bus_err_d = 1'b1;
      end
    end else if (EX_branch_taken) begin
      // Also covers a load-use in ID: that instruction is wrong-path and gets flushed.
      if_id.flush = 1'b1;
      id_ex.flush = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = EX_target;
      flush_inc   = 1'b1;
      if (!imem_ready) begin
        state_d    = StRedirPend;
        redir_pc_d = EX_target;
      end
    end else if (resume_redir) begin
      if_id.flush = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = redir_pc_q;
      if (!imem_ready) begin
        state_d = StRedirPend;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id.en    = 1'b0;
      id_ex.flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id.flush = 1'b1;
    end

    // Reset acts on the outputs immediately, not only after the next edge.
    if (!rst) begin
      pc_en       = 1'b0;
      if_id       = '{en: 1'b0, flush: 1'b1};
      id_ex       = '{en: 1'b0, flush: 1'b1};
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = '0;
      flush_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      resume_q   <= 1'b0;
      redir_pc_q <= '0;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      redir_pc_q <= redir_pc_d;
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stall_inc = !pc_en;

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (stall_inc),
    .count_o(stall_cycles)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (flush_inc),
    .count_o(flush_count)
  );

  assign PC_en          = pc_en;
  assign IF_ID_en       = if_id.en;
  assign IF_ID_flush    = if_id.flush;
  assign ID_EX_en       = id_ex.en;
  assign ID_EX_flush    = id_ex.flush;
  assign EX_MEM_en      = ex_mem_en;
  assign MEM_WB_en      = mem_wb_en;
  assign redirect_valid = redir_valid;
  assign redirect_pc    = redir_pc;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int unsigned CntW = 3;
  localparam int unsigned Tmo  = 4;

  // {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en, redirect_valid}
  localparam logic [7:0] CtlRun  = 8'b1101_0110;
  localparam logic [7:0] CtlLu   = 8'b0001_1110;
  localparam logic [7:0] CtlBr   = 8'b1111_1111;
  localparam logic [7:0] CtlFw   = 8'b0111_0110;
  localparam logic [7:0] CtlFrz  = 8'b0000_0000;
  localparam logic [7:0] CtlRst  = 8'b0010_1000;
  localparam logic [7:0] CtlPend = 8'b1111_0111;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      ID_rs1, ID_rs2, EX_rd;
  logic            ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_branch_taken;
  logic [31:0]     EX_target;
  logic            imem_ready, dmem_req, dmem_ready;
  logic            PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en;
  logic            redirect_valid, bus_err;
  logic [31:0]     redirect_pc;
  logic [CntW-1:0] stall_cycles, flush_count;
  logic [7:0]      ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctl = {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en,
                redirect_valid};

  hazard_ctrl #(
    .CNT_W       (CntW),
    .DMEM_TIMEOUT(Tmo)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ID_rs1         (ID_rs1),
    .ID_rs2         (ID_rs2),
    .ID_uses_rs1    (ID_uses_rs1),
    .ID_uses_rs2    (ID_uses_rs2),
    .EX_rd          (EX_rd),
    .EX_MemRead     (EX_MemRead),
    .EX_branch_taken(EX_branch_taken),
    .EX_target      (EX_target),
    .imem_ready     (imem_ready),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .PC_en          (PC_en),
    .IF_ID_en       (IF_ID_en),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_en       (ID_EX_en),
    .ID_EX_flush    (ID_EX_flush),
    .EX_MEM_en      (EX_MEM_en),
    .MEM_WB_en      (MEM_WB_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus_err        (bus_err),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mr;
    logic        br;
    logic [31:0] tgt;
    logic        im;
    logic        dq;
    logic        dr;
    logic [7:0]  ctl;
    int          stall;
    int          flush;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int rs1, input int rs2, input int u1, input int u2,
                              input int rd, input int mr, input int br, input int tgt,
                              input int im, input int dq, input int dr, input logic [7:0] c,
                              input int st, input int fl);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.mr = 1'(mr); v.br = 1'(br); v.tgt = 32'(tgt);
    v.im = 1'(im); v.dq = 1'(dq); v.dr = 1'(dr); v.ctl = c;
    v.stall = st; v.flush = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    ID_rs1 = '0; ID_rs2 = '0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    EX_rd = '0; EX_MemRead = 1'b0; EX_branch_taken = 1'b0; EX_target = '0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_uses_rs1 = v.u1; ID_uses_rs2 = v.u2;
    EX_rd = v.rd; EX_MemRead = v.mr; EX_branch_taken = v.br; EX_target = v.tgt;
    imem_ready = v.im; dmem_req = v.dq; dmem_ready = v.dr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'(CtlRst));
    check("rst_pc", redirect_pc, 32'h0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_flush", 32'(flush_count), 32'd0);
    check("rst_buserr", 32'(bus_err), 32'd0);
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    #2;

    vecs[0]  = mk(5, 0, 1, 0, 6, 1, 0, 0,      1, 0, 0, CtlRun, 0, 0);
    vecs[1]  = mk(5, 0, 1, 0, 5, 1, 0, 0,      1, 0, 0, CtlLu,  1, 0);
    vecs[2]  = mk(3, 7, 1, 1, 7, 1, 0, 0,      1, 0, 0, CtlLu,  1, 0);
    vecs[3]  = mk(0, 7, 0, 0, 7, 1, 0, 0,      1, 0, 0, CtlRun, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 1, 0, 0,      1, 0, 0, CtlRun, 0, 0);
    vecs[5]  = mk(5, 0, 1, 0, 5, 0, 0, 0,      1, 0, 0, CtlRun, 0, 0);
    vecs[6]  = mk(5, 0, 1, 0, 5, 1, 1, 'h100,  1, 0, 0, CtlBr,  0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, CtlFw,  1, 0);
    vecs[8]  = mk(9, 0, 1, 0, 9, 1, 0, 0,      0, 0, 0, CtlLu,  1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 'h40,   1, 1, 0, CtlFrz, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 1, 1, CtlRun, 0, 0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      if (vecs[i].ctl[0]) check($sformatf("vec%0d_pc", i), redirect_pc, vecs[i].tgt);
      next_cycle();
      set_idle();
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].stall));
      check($sformatf("vec%0d_flush", i), 32'(flush_count), 32'(vecs[i].flush));
    end

    // Data wait with a taken branch held in EX.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1; EX_target = 32'h80;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dwait_frz", 32'(ctl), 32'(CtlFrz));
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("dwait_br_ctl", 32'(ctl), 32'(CtlBr));
    check("dwait_br_pc", redirect_pc, 32'h80);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("dwait_once", 32'(ctl), 32'(CtlRun));
    check("dwait_stall", 32'(stall_cycles), 32'd3);
    check("dwait_flush", 32'(flush_count), 32'd1);
    check("dwait_buserr", 32'(bus_err), 32'd0);

    // Redirect while the fetch is waiting.
    do_reset();
    EX_branch_taken = 1'b1; EX_target = 32'h200; imem_ready = 1'b0;
    @(negedge clk);
    check("rfw_c1_ctl", 32'(ctl), 32'(CtlBr));
    check("rfw_c1_pc", redirect_pc, 32'h200);
    next_cycle();
    EX_branch_taken = 1'b0; EX_target = 32'h0;
    @(negedge clk);
    check("rfw_c2_ctl", 32'(ctl), 32'(CtlPend));
    check("rfw_c2_pc", redirect_pc, 32'h200);
    next_cycle();
    imem_ready = 1'b1;
    @(negedge clk);
    check("rfw_c3_ctl", 32'(ctl), 32'(CtlPend));
    check("rfw_c3_pc", redirect_pc, 32'h200);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("rfw_run", 32'(ctl), 32'(CtlRun));
    check("rfw_flush", 32'(flush_count), 32'd1);
    check("rfw_stall", 32'(stall_cycles), 32'd0);

    // Dmem timeout, sticky bus_err, then async reset in the middle of a wait.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("tmo_frz", 32'(ctl), 32'(CtlFrz));
      check($sformatf("tmo_buserr_c%0d", k), 32'(bus_err), 32'(k >= 5));
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("tmo_ready_ctl", 32'(ctl), 32'(CtlRun));
    check("tmo_ready_buserr", 32'(bus_err), 32'd1);
    check("tmo_stall", 32'(stall_cycles), 32'd6);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("tmo_sticky", 32'(bus_err), 32'd1);
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    check("tmo_w2_frz", 32'(ctl), 32'(CtlFrz));
    next_cycle();
    dmem_req = 1'b0;
    #2;
    check("tmo_hold_frz", 32'(ctl), 32'(CtlFrz));
    check("tmo_stall_sat", 32'(stall_cycles), 32'd7);
    rst = 1'b0;
    #1;
    check("arst_ctl", 32'(ctl), 32'(CtlRst));
    check("arst_buserr", 32'(bus_err), 32'd0);
    check("arst_stall", 32'(stall_cycles), 32'd0);
    check("arst_pc", redirect_pc, 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("arst_state_run", 32'(ctl), 32'(CtlRun));

    // Stall counter saturation on a long fetch wait.
    do_reset();
    imem_ready = 1'b0;
    @(negedge clk);
    check("sat_ctl", 32'(ctl), 32'(CtlFw));
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("sat_stall_c%0d", k), 32'(stall_cycles), 32'((k > 7) ? 7 : k));
    end

    // Freeze during a pending redirect, then a new branch overwriting the target.
    do_reset();
    EX_branch_taken = 1'b1; EX_target = 32'h300; imem_ready = 1'b0;
    @(negedge clk);
    check("rpf_br_ctl", 32'(ctl), 32'(CtlBr));
    next_cycle();
    EX_branch_taken = 1'b0; EX_target = 32'h0; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rpf_frz", 32'(ctl), 32'(CtlFrz));
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("rpf_resume_ctl", 32'(ctl), 32'(CtlPend));
    check("rpf_resume_pc", redirect_pc, 32'h300);
    next_cycle();
    dmem_req = 1'b0; dmem_ready = 1'b0; EX_branch_taken = 1'b1; EX_target = 32'h400;
    @(negedge clk);
    check("rpf_newbr_ctl", 32'(ctl), 32'(CtlBr));
    check("rpf_newbr_pc", redirect_pc, 32'h400);
    next_cycle();
    EX_branch_taken = 1'b0; EX_target = 32'h0; imem_ready = 1'b1;
    @(negedge clk);
    check("rpf_pend_ctl", 32'(ctl), 32'(CtlPend));
    check("rpf_pend_pc", redirect_pc, 32'h400);
    next_cycle();
    set_idle();
    @(negedge clk);
    check("rpf_run", 32'(ctl), 32'(CtlRun));
    check("rpf_flush", 32'(flush_count), 32'd2);
    check("rpf_stall", 32'(stall_cycles), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
